// File: rtl/heap_sort_pkg.sv
// Shared types, sizes and vector element helpers for the streaming heap sorter.
// Element 0 sits in the most significant word of the packed vector.
package heap_sort_pkg;

  localparam int ELEM_W_DEF = 32;
  localparam int N_DEF      = 6;
  localparam int IDX_W      = $clog2(N_DEF);
  localparam int SIZE_W     = IDX_W + 2;
  localparam int VEC_W      = N_DEF * ELEM_W_DEF;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    BUILD = 2'd1,
    EMIT  = 2'd2,
    SIFT  = 2'd3
  } state_t;

  localparam logic [1:0] SEL_PARENT = 2'd0;
  localparam logic [1:0] SEL_LEFT   = 2'd1;
  localparam logic [1:0] SEL_RIGHT  = 2'd2;

  typedef logic [IDX_W-1:0]             idx_t;
  typedef logic signed [ELEM_W_DEF-1:0] elem_t;
  typedef logic [VEC_W-1:0]             vec_t;

  function automatic elem_t getElem(input vec_t v, input idx_t idx);
    int pos;
    pos = (N_DEF - 1 - int'(idx)) * ELEM_W_DEF;
    return v[pos +: ELEM_W_DEF];
  endfunction

  function automatic vec_t setElem(input vec_t v, input idx_t idx, input elem_t val);
    vec_t res;
    int   pos;
    res = v;
    pos = (N_DEF - 1 - int'(idx)) * ELEM_W_DEF;
    res[pos +: ELEM_W_DEF] = val;
    return res;
  endfunction

endpackage

// File: rtl/heap_sort_stream_min3.sv
// Picks the smallest of a heap node and its present children.
// Ties keep the parent in place; equal children favour the left one.
module heap_min3
  import heap_sort_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF
) (
  input  logic signed [ELEM_W-1:0] parentVal,
  input  logic signed [ELEM_W-1:0] leftVal,
  input  logic signed [ELEM_W-1:0] rightVal,
  input  logic                     leftPresent,
  input  logic                     rightPresent,
  output logic [1:0]               minSel
);

  // Signed three-way minimum with strict-less swaps only
  always_comb begin
    minSel = SEL_PARENT;
    if (leftPresent && (!rightPresent || (leftVal <= rightVal))) begin
      if (leftVal < parentVal) begin
        minSel = SEL_LEFT;
      end else begin
        minSel = SEL_PARENT;
      end
    end else if (rightPresent) begin
      if (rightVal < parentVal) begin
        minSel = SEL_RIGHT;
      end else begin
        minSel = SEL_PARENT;
      end
    end else begin
      minSel = SEL_PARENT;
    end
  end

endmodule

// File: rtl/heap_sort_stream.sv
// Streaming heap sorter: shift in N signed words, heapify as a min-heap,
// then stream them out in ascending order over a valid/ready handshake.
module heap_sort_stream
  import heap_sort_pkg::*;
#(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int N      = N_DEF
) (
  input  logic                     system1000,
  input  logic                     system1000_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [ELEM_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ELEM_W-1:0] out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam idx_t              LAST_IDX  = idx_t'(N - 1);
  localparam idx_t              START_IDX = idx_t'(N / 2 - 1);
  localparam idx_t              ROOT_IDX  = {IDX_W{1'b0}};
  localparam idx_t              ONE_IDX   = idx_t'(1);
  localparam logic [SIZE_W-1:0] FULL_SIZE = SIZE_W'(N);
  localparam logic [SIZE_W-1:0] ONE_SIZE  = SIZE_W'(1);

  state_t              state_r, stateNext_s;
  vec_t                vec_r, vecNext_s;
  idx_t                count_r, countNext_s;
  idx_t                start_r, startNext_s;
  idx_t                cursor_r, cursorNext_s;
  logic [SIZE_W-1:0]   size_r, sizeNext_s;

  logic                inReady_r, inReadyNext_s;
  logic                outValid_r, outValidNext_s;
  elem_t               outData_r, outDataNext_s;
  logic                outLast_r, outLastNext_s;
  logic                busy_r, busyNext_s;

  // One sift step around the cursor node
  logic [SIZE_W-1:0]   leftIdx_s, rightIdx_s, grandIdx_s;
  logic                leftPresent_s, rightPresent_s;
  idx_t                leftAddr_s, rightAddr_s, childIdx_s, tailIdx_s;
  elem_t               parentVal_s, leftVal_s, rightVal_s, childVal_s;
  logic [1:0]          minSel_s;
  logic                doSwap_s, newHasChild_s, siftEnd_s;
  vec_t                swappedVec_s;

  assign leftIdx_s      = {1'b0, cursor_r, 1'b1};
  assign rightIdx_s     = leftIdx_s + ONE_SIZE;
  assign leftPresent_s  = leftIdx_s < size_r;
  assign rightPresent_s = rightIdx_s < size_r;
  assign leftAddr_s     = leftPresent_s ? leftIdx_s[IDX_W-1:0] : cursor_r;
  assign rightAddr_s    = rightPresent_s ? rightIdx_s[IDX_W-1:0] : cursor_r;
  assign parentVal_s    = getElem(vec_r, cursor_r);
  assign leftVal_s      = getElem(vec_r, leftAddr_s);
  assign rightVal_s     = getElem(vec_r, rightAddr_s);

  heap_min3 #(.ELEM_W(ELEM_W_DEF)) uMin3 (
    .parentVal    (parentVal_s),
    .leftVal      (leftVal_s),
    .rightVal     (rightVal_s),
    .leftPresent  (leftPresent_s),
    .rightPresent (rightPresent_s),
    .minSel       (minSel_s)
  );

  assign doSwap_s      = minSel_s != SEL_PARENT;
  assign childIdx_s    = (minSel_s == SEL_RIGHT) ? rightAddr_s : leftAddr_s;
  assign childVal_s    = (minSel_s == SEL_RIGHT) ? rightVal_s : leftVal_s;
  assign swappedVec_s  = setElem(setElem(vec_r, cursor_r, childVal_s), childIdx_s, parentVal_s);
  assign grandIdx_s    = {1'b0, childIdx_s, 1'b1};
  assign newHasChild_s = grandIdx_s < size_r;
  assign siftEnd_s     = !doSwap_s || !newHasChild_s;
  assign tailIdx_s     = idx_t'(size_r - ONE_SIZE);

  // State, datapath and output registers
  always_ff @(posedge system1000) begin
    if (system1000_rst) begin
      state_r    <= LOAD;
      vec_r      <= '0;
      count_r    <= ROOT_IDX;
      start_r    <= ROOT_IDX;
      cursor_r   <= ROOT_IDX;
      size_r     <= {SIZE_W{1'b0}};
      inReady_r  <= 1'b1;
      outValid_r <= 1'b0;
      outData_r  <= '0;
      outLast_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= stateNext_s;
      vec_r      <= vecNext_s;
      count_r    <= countNext_s;
      start_r    <= startNext_s;
      cursor_r   <= cursorNext_s;
      size_r     <= sizeNext_s;
      inReady_r  <= inReadyNext_s;
      outValid_r <= outValidNext_s;
      outData_r  <= outDataNext_s;
      outLast_r  <= outLastNext_s;
      busy_r     <= busyNext_s;
    end
  end

  // Next state and next datapath contents
  always_comb begin
    stateNext_s  = state_r;
    vecNext_s    = vec_r;
    countNext_s  = count_r;
    startNext_s  = start_r;
    cursorNext_s = cursor_r;
    sizeNext_s   = size_r;
    case (state_r)
      LOAD: begin
        if (in_valid) begin
          vecNext_s = {vec_r[VEC_W-ELEM_W_DEF-1:0], in_data};
          if (count_r == LAST_IDX) begin
            countNext_s  = ROOT_IDX;
            sizeNext_s   = FULL_SIZE;
            startNext_s  = START_IDX;
            cursorNext_s = START_IDX;
            stateNext_s  = BUILD;
          end else begin
            countNext_s = count_r + ONE_IDX;
          end
        end else begin
          vecNext_s = vec_r;
        end
      end
      BUILD: begin
        if (doSwap_s) begin
          vecNext_s    = swappedVec_s;
          cursorNext_s = childIdx_s;
        end else begin
          vecNext_s = vec_r;
        end
        // A finished sift moves on to the next internal node, overriding the cursor
        if (siftEnd_s) begin
          if (start_r == ROOT_IDX) begin
            stateNext_s = EMIT;
          end else begin
            startNext_s  = start_r - ONE_IDX;
            cursorNext_s = start_r - ONE_IDX;
          end
        end else begin
          stateNext_s = BUILD;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (size_r == ONE_SIZE) begin
            stateNext_s = LOAD;
            countNext_s = ROOT_IDX;
          end else begin
            vecNext_s    = setElem(vec_r, ROOT_IDX, getElem(vec_r, tailIdx_s));
            sizeNext_s   = size_r - ONE_SIZE;
            cursorNext_s = ROOT_IDX;
            stateNext_s  = SIFT;
          end
        end else begin
          stateNext_s = EMIT;
        end
      end
      SIFT: begin
        if (doSwap_s) begin
          vecNext_s    = swappedVec_s;
          cursorNext_s = childIdx_s;
        end else begin
          vecNext_s = vec_r;
        end
        if (siftEnd_s) begin
          stateNext_s = EMIT;
        end else begin
          stateNext_s = SIFT;
        end
      end
      default: begin
        stateNext_s = LOAD;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    inReadyNext_s  = stateNext_s == LOAD;
    outValidNext_s = stateNext_s == EMIT;
    busyNext_s     = stateNext_s != LOAD;
    if (stateNext_s == EMIT) begin
      outDataNext_s = getElem(vecNext_s, ROOT_IDX);
      outLastNext_s = sizeNext_s == ONE_SIZE;
    end else begin
      outDataNext_s = '0;
      outLastNext_s = 1'b0;
    end
  end

  assign in_ready  = inReady_r;
  assign out_valid = outValid_r;
  assign out_data  = outData_r;
  assign out_last  = outLast_r;
  assign busy      = busy_r;

endmodule

// File: doc/heap_sort_stream.md
Name: heap_sort_stream

Overview:
- Sequential front end for the HeapSort datapath.
- Accepts a stream of N signed words and packs them into an N-element vector by shift-in at the low end.
- Heapifies the vector in place as a min-heap, then streams the words out in ascending order with a valid/ready handshake.
- Feeds the downstream collector and replaces the purely combinational vector-append stages with one clocked engine.

Parameters:
- ELEM_W, 32, width of each signed element.
- N, 6, elements per sort batch; packed vector width is N*ELEM_W (192).

Ports:
- system1000, input, 1, clock.
- system1000_rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, in_data valid.
- in_ready, output, 1, block accepts in_data this cycle.
- in_data, input, ELEM_W, signed element to load.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts out_data.
- out_data, output, ELEM_W, next smallest element (signed).
- out_last, output, 1, marks the final element of a batch.
- busy, output, 1, high in any state other than LOAD.

Behaviour:
- One clock; reset is synchronous and active-high.
- Storage layout:
  - Vector register vec[N*ELEM_W-1:0].
  - Element i occupies bits [(N-i)*ELEM_W-1 : (N-1-i)*ELEM_W].
  - Load: vec <= {vec[(N-1)*ELEM_W-1:0], in_data}, so the first word loaded ends up as element 0.
- Reset (takes priority over everything, including mid-operation):
  - state=LOAD, count=0, size=0, vec=0.
  - Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0.
  - An in-progress batch is discarded.
- All comparisons are signed. Ties never swap: a parent equal to its smallest child stays put, and on equal children the left child wins.
- States:
  - LOAD:
    - in_ready=1.
    - Each in_valid&in_ready cycle shifts in one word and increments count.
    - On the N-th accept: size<=N, start<=N/2-1, cursor<=N/2-1, go BUILD.
  - BUILD:
    - One sift step per cycle.
    - Step: m = index of the smallest of {cursor, 2*cursor+1, 2*cursor+2}, counting only children with index < size.
    - If m != cursor: swap elements cursor and m, cursor<=m.
    - The sift ends in the same cycle if there is no swap, or if the new cursor has no child < size.
    - At sift end: if start==0 go EMIT; else start<=start-1 and cursor<=start-1.
    - For N=6, BUILD takes at most 4 cycles, so out_valid rises no later than 5 cycles after the last input handshake.
  - EMIT:
    - out_valid=1, out_data=element 0, out_last=(size==1).
    - out_data and out_last are held stable while out_valid&&!out_ready.
    - On handshake with size==1: go LOAD, count<=0.
    - On handshake with size>1: element 0 <= element size-1, size<=size-1, cursor<=0, go SIFT.
  - SIFT: same step rule as BUILD. At sift end go EMIT (at the earliest, the next cycle).
- in_ready=0 outside LOAD; in_data is ignored there.
- out_valid=0 outside EMIT.
- Throughput: N input cycles + ≤4 BUILD cycles + N emits + ≤2 sift cycles per extraction.

Decomposition:
- Package heap_sort_pkg holds:
  - ELEM_W and N defaults.
  - IDX_W = clog2(N).
  - State enum {LOAD, BUILD, EMIT, SIFT}.
  - Element get/set helper functions for vec indexing.
- Sub-module heap_min3: combinational.
  - Inputs: parent, left, right values; left/right-present flags.
  - Output: 2-bit selector for the smallest, applying the tie rules above.
  - Instantiated once by the FSM.

Test Plan:
- Basic sort: load 5,3,8,1,9,2 with out_ready=1 -> out_data 1,2,3,5,8,9; out_last only on 9; in_ready returns 1 the cycle after.
- Signed extremes: load -1, 0x7FFFFFFF, 0x80000000, 0, 7, -1 -> -2147483648, -1, -1, 0, 7, 2147483647.
- Backpressure: hold out_ready=0 for 4 cycles at the first EMIT of the basic set -> out_valid stays 1 and out_data stays 1 throughout; sequence is otherwise unchanged.
- Input ignored while busy: drive in_valid=1 with data 99 during BUILD/EMIT -> in_ready=0; 99 never appears; the next batch is sorted correctly.
- Reset mid-operation: assert system1000_rst during SIFT after the second output -> next cycle out_valid=0, in_ready=1, busy=0; a fresh batch 6,5,4,3,2,1 -> 1..6.
- Duplicates: load 4,4,4,4,4,4 -> six 4s, out_last on the sixth, no extra cycles beyond one sift check per extraction.
